// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one word-aligned request at a
// time and presents each returned instruction with its PC through a valid/ready slot.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
  input  logic            if_ready_i,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;

  logic            slot_free;
  logic            consume;
  logic            req_valid;
  logic            req_fire;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_bits;

  // Handshakes: a transfer happens in any cycle where valid && ready are both
  // high at the rising edge; valid never waits on ready, and a held output
  // (if_valid && !if_ready) keeps if_pc/if_instr stable until consumed.
  assign slot_free       = !if_valid_q || if_ready_i;
  assign consume         = if_valid_q && if_ready_i;
  assign req_valid       = (state_q == S_REQ) && !stall_i && !redirect_valid_i && slot_free;
  assign req_fire        = req_valid && imem_req_ready_i;
  assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc_i[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    if (redirect_valid_i) begin
      // A redirect kills everything, including a response arriving this cycle.
      pc_d       = redirect_target;
      if_valid_d = 1'b0;
      unique case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = S_REQ;
        S_WAIT:  state_d = imem_rsp_valid_i ? S_REQ : S_DRAIN;
        S_DRAIN: state_d = imem_rsp_valid_i ? S_REQ : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (consume) begin
            if_valid_d = 1'b0;
          end
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid_i) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem_rsp_data_i;
            state_d    = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rsp_valid_i) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc_q;
  assign if_valid_o       = if_valid_q;
  assign if_pc_o          = if_pc_q;
  assign if_instr_o       = if_instr_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle-stepped memory model with fixed
// latency, per-scenario tasks with hand-computed expectations per cycle.
module tb_fetch_stage;

  logic        clk_i;
  logic        rst_ni;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_ready_i;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;

  // memory model state
  int          mem_k   = 1;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr;

  // snapshot taken at the falling edge of the last stepped cycle
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [1:0]  s_state;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .if_valid_o       (if_valid_o),
    .if_pc_o          (if_pc_o),
    .if_instr_o       (if_instr_o),
    .if_ready_i       (if_ready_i),
    .dbg_state_o      (dbg_state_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  // Step one cycle: sample at negedge, then after the rising edge update memory.
  task automatic cycle();
    logic        fire;
    logic [31:0] fa;
    @(negedge clk_i);
    s_rv    = imem_req_valid_o;
    s_addr  = imem_req_addr_o;
    s_iv    = if_valid_o;
    s_pc    = if_pc_o;
    s_instr = if_instr_o;
    s_state = dbg_state_o;
    fire    = imem_req_valid_o && imem_req_ready_i;
    fa      = imem_req_addr_o;
    @(posedge clk_i);
    #1;
    imem_rsp_valid_i = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = instr_of(rsp_addr);
      end
    end
    if (fire) begin
      rsp_addr = fa;
      rsp_cnt  = mem_k - 1;
      if (rsp_cnt == 0) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = instr_of(rsp_addr);
      end
    end
  endtask

  // Reset, release, and step through cycle 0; returns at the start of cycle 1.
  task automatic do_reset(input int k);
    rst_ni           = 1'b0;
    mem_k            = k;
    rsp_cnt          = 0;
    imem_rsp_valid_i = 1'b0;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    if_ready_i       = 1'b1;
    cycle();
    cycle();
    rst_ni = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    cycle();
    total++; if (s_rv !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %0b want 0", s_rv); end
    total++; if (s_addr !== 32'h100) begin bad++; $display("FAIL rst_req_addr: got %h want 00000100", s_addr); end
    total++; if (s_iv !== 1'b0) begin bad++; $display("FAIL rst_if_valid: got %0b want 0", s_iv); end
    total++; if (s_pc !== 32'h0) begin bad++; $display("FAIL rst_if_pc: got %h want 0", s_pc); end
    total++; if (s_instr !== 32'h0) begin bad++; $display("FAIL rst_if_instr: got %h want 0", s_instr); end
    total++; if (s_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", s_state); end
    rst_ni = 1'b1;
    cycle();
    total++; if (s_rv !== 1'b0) begin bad++; $display("FAIL rst_c0_req_valid: got %0b want 0", s_rv); end
    total++; if (s_state !== 2'd0) begin bad++; $display("FAIL rst_c0_state: got %0d want 0", s_state); end
  endtask

  // continues from test_reset at cycle 1, RESET_PC=0x100, k=1
  task automatic test_sequential();
    bit          e_rv [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    bit          e_iv [8] = '{0, 0, 0, 1, 0, 1, 0, 1};
    logic [31:0] e_addr [8] = '{32'h0, 32'h100, 32'h104, 32'h104, 32'h108, 32'h108, 32'h10C, 32'h10C};
    logic [31:0] e_pc [8] = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h104, 32'h0, 32'h108};
    for (int c = 1; c <= 7; c++) begin
      cycle();
      total++; if (s_rv !== e_rv[c]) begin bad++; $display("FAIL seq_req_valid c%0d: got %0b want %0b", c, s_rv, e_rv[c]); end
      total++; if (s_addr !== e_addr[c]) begin bad++; $display("FAIL seq_req_addr c%0d: got %h want %h", c, s_addr, e_addr[c]); end
      total++; if (s_iv !== e_iv[c]) begin bad++; $display("FAIL seq_if_valid c%0d: got %0b want %0b", c, s_iv, e_iv[c]); end
      if (e_iv[c]) begin
        total++; if (s_pc !== e_pc[c]) begin bad++; $display("FAIL seq_if_pc c%0d: got %h want %h", c, s_pc, e_pc[c]); end
        total++; if (s_instr !== instr_of(e_pc[c])) begin bad++; $display("FAIL seq_if_instr c%0d: got %h want %h", c, s_instr, instr_of(e_pc[c])); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit          e_rv [3] = '{1, 0, 1};
    bit          e_iv [3] = '{1, 0, 1};
    logic [31:0] e_addr [3] = '{32'h108, 32'h10C, 32'h10C};
    logic [31:0] e_pc [3] = '{32'h104, 32'h0, 32'h108};
    do_reset(1);
    for (int c = 1; c <= 4; c++) cycle();
    if_ready_i = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      cycle();
      total++; if (s_rv !== 1'b0) begin bad++; $display("FAIL bp_hold_req_valid c%0d: got %0b want 0", c, s_rv); end
      total++; if (s_iv !== 1'b1) begin bad++; $display("FAIL bp_hold_if_valid c%0d: got %0b want 1", c, s_iv); end
      total++; if (s_pc !== 32'h104) begin bad++; $display("FAIL bp_hold_if_pc c%0d: got %h want 00000104", c, s_pc); end
      total++; if (s_instr !== 32'h0104_0013) begin bad++; $display("FAIL bp_hold_if_instr c%0d: got %h want 01040013", c, s_instr); end
      total++; if (s_addr !== 32'h108) begin bad++; $display("FAIL bp_hold_addr c%0d: got %h want 00000108", c, s_addr); end
    end
    if_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (s_rv !== e_rv[i]) begin bad++; $display("FAIL bp_rel_req_valid c%0d: got %0b want %0b", 10 + i, s_rv, e_rv[i]); end
      total++; if (s_addr !== e_addr[i]) begin bad++; $display("FAIL bp_rel_addr c%0d: got %h want %h", 10 + i, s_addr, e_addr[i]); end
      total++; if (s_iv !== e_iv[i]) begin bad++; $display("FAIL bp_rel_if_valid c%0d: got %0b want %0b", 10 + i, s_iv, e_iv[i]); end
      if (e_iv[i]) begin
        total++; if (s_pc !== e_pc[i]) begin bad++; $display("FAIL bp_rel_if_pc c%0d: got %h want %h", 10 + i, s_pc, e_pc[i]); end
      end
    end
  endtask

  task automatic test_redirect_wait();
    bit          rd_v [11] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] rd_pc [11] = '{32'h0, 32'h200, 32'h0, 32'h400, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    bit          e_rv [11] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    bit          e_iv [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [1:0]  e_st [11] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [31:0] e_addr [11] = '{32'h0, 32'h100, 32'h200, 32'h204, 32'h400, 32'h400,
                                 32'h400, 32'h404, 32'h404, 32'h404, 32'h404};
    do_reset(3);
    for (int c = 1; c <= 10; c++) begin
      redirect_valid_i = rd_v[c];
      redirect_pc_i    = rd_pc[c];
      cycle();
      redirect_valid_i = 1'b0;
      total++; if (s_rv !== e_rv[c]) begin bad++; $display("FAIL rdw_req_valid c%0d: got %0b want %0b", c, s_rv, e_rv[c]); end
      total++; if (s_addr !== e_addr[c]) begin bad++; $display("FAIL rdw_addr c%0d: got %h want %h", c, s_addr, e_addr[c]); end
      total++; if (s_state !== e_st[c]) begin bad++; $display("FAIL rdw_state c%0d: got %0d want %0d", c, s_state, e_st[c]); end
      total++; if (s_iv !== e_iv[c]) begin bad++; $display("FAIL rdw_if_valid c%0d: got %0b want %0b", c, s_iv, e_iv[c]); end
      if (e_iv[c]) begin
        total++; if (s_pc !== 32'h400) begin bad++; $display("FAIL rdw_if_pc c%0d: got %h want 00000400", c, s_pc); end
        total++; if (s_instr !== 32'h0400_0013) begin bad++; $display("FAIL rdw_if_instr c%0d: got %h want 04000013", c, s_instr); end
      end
    end
  endtask

  task automatic test_redirect_coincident();
    bit          e_rv [6] = '{0, 1, 0, 1, 0, 1};
    bit          e_iv [6] = '{0, 0, 0, 0, 0, 1};
    logic [1:0]  e_st [6] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    logic [31:0] e_addr [6] = '{32'h0, 32'h100, 32'h104, 32'h800, 32'h804, 32'h804};
    do_reset(1);
    for (int c = 1; c <= 5; c++) begin
      redirect_valid_i = (c == 2);
      redirect_pc_i    = 32'h803;
      cycle();
      redirect_valid_i = 1'b0;
      total++; if (s_rv !== e_rv[c]) begin bad++; $display("FAIL coin_req_valid c%0d: got %0b want %0b", c, s_rv, e_rv[c]); end
      total++; if (s_addr !== e_addr[c]) begin bad++; $display("FAIL coin_addr c%0d: got %h want %h", c, s_addr, e_addr[c]); end
      total++; if (s_state !== e_st[c]) begin bad++; $display("FAIL coin_state c%0d: got %0d want %0d", c, s_state, e_st[c]); end
      total++; if (s_iv !== e_iv[c]) begin bad++; $display("FAIL coin_if_valid c%0d: got %0b want %0b", c, s_iv, e_iv[c]); end
      if (e_iv[c]) begin
        total++; if (s_pc !== 32'h800) begin bad++; $display("FAIL coin_if_pc c%0d: got %h want 00000800", c, s_pc); end
        total++; if (s_instr !== 32'h0800_0013) begin bad++; $display("FAIL coin_if_instr c%0d: got %h want 08000013", c, s_instr); end
      end
    end
  endtask

  task automatic test_stall_wrap();
    bit          st_v [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    bit          rdy  [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 1};
    bit          e_rv [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
    bit          e_iv [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [31:0] e_addr [9] = '{32'h0, 32'h100, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0};
    do_reset(1);
    for (int c = 1; c <= 8; c++) begin
      redirect_valid_i = (c == 1);
      redirect_pc_i    = 32'hFFFF_FFFC;
      stall_i          = st_v[c];
      imem_req_ready_i = rdy[c];
      cycle();
      redirect_valid_i = 1'b0;
      stall_i          = 1'b0;
      imem_req_ready_i = 1'b1;
      total++; if (s_rv !== e_rv[c]) begin bad++; $display("FAIL wrap_req_valid c%0d: got %0b want %0b", c, s_rv, e_rv[c]); end
      total++; if (s_addr !== e_addr[c]) begin bad++; $display("FAIL wrap_addr c%0d: got %h want %h", c, s_addr, e_addr[c]); end
      total++; if (s_iv !== e_iv[c]) begin bad++; $display("FAIL wrap_if_valid c%0d: got %0b want %0b", c, s_iv, e_iv[c]); end
      if (e_iv[c]) begin
        total++; if (s_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_if_pc c%0d: got %h want fffffffc", c, s_pc); end
        total++; if (s_instr !== 32'hFFFC_0013) begin bad++; $display("FAIL wrap_if_instr c%0d: got %h want fffc0013", c, s_instr); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1);
    for (int c = 1; c <= 3; c++) cycle();
    // now early in cycle 4: WAIT for 0x104, if_pc holds 0x100
    #2;
    rst_ni           = 1'b0;
    rsp_cnt          = 0;
    imem_rsp_valid_i = 1'b0;
    #1;
    total++; if (imem_req_valid_o !== 1'b0) begin bad++; $display("FAIL arst_req_valid: got %0b want 0", imem_req_valid_o); end
    total++; if (imem_req_addr_o !== 32'h100) begin bad++; $display("FAIL arst_req_addr: got %h want 00000100", imem_req_addr_o); end
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL arst_if_valid: got %0b want 0", if_valid_o); end
    total++; if (if_pc_o !== 32'h0) begin bad++; $display("FAIL arst_if_pc: got %h want 0", if_pc_o); end
    total++; if (if_instr_o !== 32'h0) begin bad++; $display("FAIL arst_if_instr: got %h want 0", if_instr_o); end
    total++; if (dbg_state_o !== 2'd0) begin bad++; $display("FAIL arst_state: got %0d want 0", dbg_state_o); end
    cycle();
    rst_ni = 1'b1;
    cycle();
    total++; if (s_rv !== 1'b0) begin bad++; $display("FAIL arst_c0_req_valid: got %0b want 0", s_rv); end
    cycle();
    total++; if (s_rv !== 1'b1) begin bad++; $display("FAIL arst_c1_req_valid: got %0b want 1", s_rv); end
    total++; if (s_addr !== 32'h100) begin bad++; $display("FAIL arst_c1_addr: got %h want 00000100", s_addr); end
  endtask

  initial begin
    rst_ni           = 1'b0;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    if_ready_i       = 1'b1;
    rsp_addr         = '0;

    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_stall_wrap();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
